mult_seq_ctrl: RTL and testbench
================================

# mult_seq_ctrl

Sequential 32x32 multiplier controller for the HI/LO path of the MIPS datapath, serving MULT and MULTU. It latches two 32-bit operands on a start pulse and runs a 32-iteration shift-add loop over a 64-bit product register. A sign-fix cycle follows. It then presents the 64-bit result on hi/lo with a one-cycle done pulse. Core control holds off HI/LO readers while busy is high.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH; counter is clog2(WIDTH) bits.
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- a  input  WIDTH  multiplicand (rs); sampled with start.
- b  input  WIDTH  multiplier (rt); sampled with start.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; hi/lo valid.
- hi  output  WIDTH  upper product word, registered.
- lo  output  WIDTH  lower product word, registered.

## Operation
- States: IDLE, RUN, FIX, DONE.
  - IDLE -> RUN on start.
  - RUN -> FIX when count == WIDTH-1.
  - FIX -> DONE, unconditionally.
  - DONE -> IDLE, unconditionally.
- Operand capture (IDLE with start):
  - Unsigned: mcand = a; prod = {0, b}.
  - Signed: mcand = |a|; prod = {0, |b|}; neg = a[MSB] ^ b[MSB].
  - |x| = x when the MSB is 0, else ~x+1.
  - 0x80000000 maps to magnitude 0x80000000, treated as unsigned. No overflow case.
  - count = 0.
- RUN, each cycle:
  - If prod[0] == 1, upper = prod[2W-1:W] + mcand as a (W+1)-bit sum, carry kept; otherwise upper = prod[2W-1:W] with carry 0.
  - Then prod = {carry, upper, prod[W-1:1]}, a logical right shift by 1.
  - count increments.
  - Exactly WIDTH iterations.
- FIX:
  - If neg, {hi, lo} <= ~prod + 1 (64-bit); otherwise {hi, lo} <= prod.
  - The FIX cycle is always taken, so latency is fixed.
- DONE: done = 1; hi/lo hold.
- hi/lo change only on the FIX edge. They hold the last result indefinitely, including while a new operation runs.
- start is ignored in RUN, FIX and DONE; no queuing.
- Changes on a, b or is_signed while busy have no effect.
- Reset, in any state including mid-RUN:
  - state IDLE, busy 0, done 0, hi 0, lo 0, count 0, prod 0, neg 0.
  - The aborted operation produces no done and no write.
- Reset and start in the same cycle: reset wins; the request is dropped.

## Timing
- Edges are numbered from capture. E0 is the edge where start=1 is sampled in IDLE.
- busy is high from after E0 through E34.
- Iterations occur on E1..E32. The FIX write happens on E33.
- done is high, and new hi/lo visible, for the one cycle between E33 and E34.
- busy stays high during the DONE cycle and drops after E34.
- The earliest next capture is E35, so the issue interval is 35 cycles.
- Outputs are all registered; there are no combinational paths from inputs to outputs.
- Reset values: busy 0, done 0, hi 0x00000000, lo 0x00000000.

## Test plan
- **Basic unsigned:** MULTU, a=3, b=5, start at E0.
  - busy rises after E0; done appears exactly after E33.
  - hi=0x00000000, lo=0x0000000F; busy low after E34.
- **Unsigned max:** MULTU, a=b=0xFFFFFFFF.
  - hi=0xFFFFFFFE, lo=0x00000001.
- **Signed mixed sign:** MULT, a=0xFFFFFFFD (-3), b=7.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
  - Then MULT, a=-3, b=-7 gives hi=0, lo=0x00000015.
- **Signed extreme:** MULT, a=b=0x80000000.
  - hi=0x40000000, lo=0x00000000.
  - MULT, a=0x80000000, b=1 gives hi=0xFFFFFFFF, lo=0x80000000.
- **Protocol:** complete 6*7 (lo=42). Then start a new op, and during RUN pulse start with different a/b and toggle a/b every cycle.
  - hi/lo stay 42 until the FIX edge of the new op.
  - Only the originally captured op completes; exactly one done pulse per accepted start.
- **Reset mid-run:** start MULTU 9*9, assert reset on E10.
  - Next cycle: busy 0, done 0, hi=lo=0, and no done for 40 cycles.
  - Then MULTU 9*9 yields lo=0x51 on schedule.
  - Reset asserted together with start: no capture.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add 32x32 multiplier for the HI/LO path (MULT / MULTU).
// Fixed 35-cycle issue interval: capture, 32 iterations, sign fix, done.
module mult_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mcand;
    logic [PW-1:0]    r_prod;
    logic             r_neg;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_capture;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_sum;
    logic [PW-1:0]    w_prod_step;
    logic [PW-1:0]    w_result;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (i_start) w_state_next = StRun;
            StRun:  if (r_count == CW'(WIDTH - 1)) w_state_next = StFix;
            StFix:  w_state_next = StDone;
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    assign w_capture = (r_state == StIdle) && i_start;

    // Most negative value's magnitude fits when read as unsigned.
    assign w_a_mag = (i_is_signed && i_a[WIDTH-1]) ? (~i_a + WIDTH'(1)) : i_a;
    assign w_b_mag = (i_is_signed && i_b[WIDTH-1]) ? (~i_b + WIDTH'(1)) : i_b;

    assign w_sum = r_prod[0] ? ({1'b0, r_prod[PW-1:WIDTH]} + {1'b0, r_mcand})
                             : {1'b0, r_prod[PW-1:WIDTH]};
    assign w_prod_step = {w_sum, r_prod[WIDTH-1:1]};
    assign w_result    = r_neg ? (~r_prod + PW'(1)) : r_prod;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_neg   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            if (w_capture) begin
                r_count <= '0;
                r_mcand <= w_a_mag;
                r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
                r_neg   <= i_is_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            end else if (r_state == StRun) begin
                r_count <= r_count + CW'(1);
                r_prod  <= w_prod_step;
            end
            if (r_state == StFix) begin
                {r_hi, r_lo} <= w_result;
            end
        end
    end

    assign o_busy = (r_state != StIdle);
    assign o_done = (r_state == StDone);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: spec vectors, protocol/reset sequences,
// and randomized operands checked against a 64-bit arithmetic model.
module tb_mult_seq_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic        i_is_signed;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int n_cmp = 0;
    int n_err = 0;

    mult_seq_ctrl #(.WIDTH(32)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_is_signed (i_is_signed),
        .i_a         (i_a),
        .i_b         (i_b),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_hi        (o_hi),
        .o_lo        (o_lo)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference product straight from integer arithmetic.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        if (s) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            return 64'(sa * sb);
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        return 64'(ua * ub);
    endfunction

    // Launch one op, scramble inputs while busy, check latency and busy framing.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [63:0] res);
        int first;
        first = -1;
        res   = '0;
        @(negedge i_clk);
        i_a = a; i_b = b; i_is_signed = s; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("busy_after_capture", 64'(o_busy), 64'd1);
        for (int k = 0; k < 60; k++) begin
            if (o_done) begin
                first = k;
                res   = {o_hi, o_lo};
                break;
            end
            i_a = $urandom; i_b = $urandom; i_is_signed = 1'($urandom_range(0, 1));
            @(negedge i_clk);
        end
        chk("done_latency", 64'(first), 64'd33);
        chk("busy_in_done", 64'(o_busy), 64'd1);
        @(negedge i_clk);
        chk("busy_after_e34", 64'(o_busy), 64'd0);
        chk("done_single_cycle", 64'(o_done), 64'd0);
    endtask

    vec_t        vecs[8];
    logic [63:0] res;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          dones;
    int          first;
    int          hold_bad;

    initial begin
        vecs[0] = '{32'd3,        32'd5,        1'b0, 32'h00000000, 32'h0000000F};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{32'hFFFFFFFD, 32'd7,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[3] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 1'b1, 32'h00000000, 32'h00000015};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
        vecs[5] = '{32'h80000000, 32'd1,        1'b1, 32'hFFFFFFFF, 32'h80000000};
        vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};
        vecs[7] = '{32'd0,        32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000000};

        i_reset = 1'b1; i_start = 1'b0; i_is_signed = 1'b0; i_a = '0; i_b = '0;
        repeat (3) @(negedge i_clk);
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_done", 64'(o_done), 64'd0);
        chk("reset_hilo", {o_hi, o_lo}, 64'd0);
        i_reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, res);
            chk($sformatf("vec%0d_result", i), res, {vecs[i].hi, vecs[i].lo});
        end

        // Protocol: result 42 must hold while a new op runs under noisy inputs.
        do_op(32'd6, 32'd7, 1'b0, res);
        chk("proto_42", res, 64'd42);
        @(negedge i_clk);
        i_a = 32'd100; i_b = 32'd200; i_is_signed = 1'b0; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        dones = 0; first = -1; hold_bad = 0; res = '0;
        for (int k = 0; k < 45; k++) begin
            if (o_done) begin
                dones++;
                if (first < 0) begin
                    first = k;
                    res   = {o_hi, o_lo};
                end
            end else if (first < 0 && {o_hi, o_lo} !== 64'd42) begin
                hold_bad++;
            end
            if (k < 30) begin
                i_start = 1'($urandom_range(0, 1));
                i_a = $urandom; i_b = $urandom; i_is_signed = 1'($urandom_range(0, 1));
            end else begin
                i_start = 1'b0;
            end
            @(negedge i_clk);
        end
        chk("proto_done_count", 64'(dones), 64'd1);
        chk("proto_done_latency", 64'(first), 64'd33);
        chk("proto_result", res, 64'd20000);
        chk("proto_hold", 64'(hold_bad), 64'd0);
        chk("proto_idle_after", 64'(o_busy), 64'd0);

        // Reset mid-run: sampled at E10, clears everything, no late done.
        @(negedge i_clk);
        i_a = 32'd9; i_b = 32'd9; i_is_signed = 1'b0; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (9) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        chk("rst_mid_busy", 64'(o_busy), 64'd0);
        chk("rst_mid_done", 64'(o_done), 64'd0);
        chk("rst_mid_hilo", {o_hi, o_lo}, 64'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_done || o_busy) dones++;
            @(negedge i_clk);
        end
        chk("rst_mid_quiet", 64'(dones), 64'd0);
        do_op(32'd9, 32'd9, 1'b0, res);
        chk("rst_then_9x9", res, 64'h51);

        // Reset and start together: request dropped.
        @(negedge i_clk);
        i_a = 32'd5; i_b = 32'd5; i_start = 1'b1; i_reset = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0; i_reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_done || o_busy) dones++;
            @(negedge i_clk);
        end
        chk("rst_start_dropped", 64'(dones), 64'd0);

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i % 5 == 0) ra = 32'h80000000;
            if (i % 7 == 0) rb = 32'hFFFFFFFF;
            do_op(ra, rb, rs, res);
            chk($sformatf("rand%0d_%h_%h_%0d", i, ra, rb, rs), res, model(ra, rb, rs));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
